// File: rtl/normalize_counter.sv
`default_nettype none
// ============================================================================
// Module   : normalize_counter
// Purpose  : Iterative mantissa normalizer; shifts until MSB set, reports count
// Revision : 1.0  initial release
// ============================================================================
module normalize_counter #(
   parameter int SIZE   = 64,
   parameter int COARSE = 8
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_start,
   input  logic [SIZE-1:0]            i_d,
   input  logic                       i_carry,
   output logic [SIZE-1:0]            o_q,
   output logic [$clog2(SIZE)+1:0]    o_shift_n,
   output logic                       o_shift_right,
   output logic                       o_sticky,
   output logic                       o_zero,
   output logic                       o_busy,
   output logic                       o_done
);

   localparam int SW = $clog2(SIZE) + 2;
   localparam logic [SW-1:0] c_coarse = SW'(COARSE);
   localparam logic [SW-1:0] c_one    = SW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LEFT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state, w_state_next;
   logic [SIZE-1:0] r_q, w_q_next;
   logic [SW-1:0]   r_shift_n, w_shift_n_next;
   logic            r_right, w_right_next;
   logic            r_sticky, w_sticky_next;
   logic            r_zero, w_zero_next;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_q       <= '0;
         r_shift_n <= '0;
         r_right   <= 1'b0;
         r_sticky  <= 1'b0;
         r_zero    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_q       <= w_q_next;
         r_shift_n <= w_shift_n_next;
         r_right   <= w_right_next;
         r_sticky  <= w_sticky_next;
         r_zero    <= w_zero_next;
      end
   end

   always_comb begin
      w_state_next   = r_state;
      w_q_next       = r_q;
      w_shift_n_next = r_shift_n;
      w_right_next   = r_right;
      w_sticky_next  = r_sticky;
      w_zero_next    = r_zero;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_shift_n_next = '0;
               w_right_next   = 1'b0;
               w_sticky_next  = 1'b0;
               w_zero_next    = 1'b0;
               if (i_carry) begin
                  w_q_next       = {1'b1, i_d[SIZE-1:1]};
                  w_shift_n_next = c_one;
                  w_right_next   = 1'b1;
                  w_sticky_next  = i_d[0];
                  w_state_next   = S_DONE;
               end else if (i_d == '0) begin
                  w_q_next     = '0;
                  w_zero_next  = 1'b1;
                  w_state_next = S_DONE;
               end else begin
                  w_q_next     = i_d;
                  w_state_next = S_LEFT;
               end
            end
         end
         S_LEFT: begin
            // Coarse step only when the whole top window is zero, so no 1 is lost
            if (r_q[SIZE-1]) begin
               w_state_next = S_DONE;
            end else if (r_q[SIZE-1 -: COARSE] == '0) begin
               w_q_next       = r_q << COARSE;
               w_shift_n_next = r_shift_n + c_coarse;
            end else begin
               w_q_next       = r_q << 1;
               w_shift_n_next = r_shift_n + c_one;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign o_q           = r_q;
   assign o_shift_n     = r_shift_n;
   assign o_shift_right = r_right;
   assign o_sticky      = r_sticky;
   assign o_zero        = r_zero;
   assign o_busy        = (r_state != S_IDLE);
   assign o_done        = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_normalize_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_normalize_counter
// Purpose  : Directed table-driven bench for normalize_counter
// Revision : 1.0  initial release
// ============================================================================
module tb_normalize_counter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [63:0] d;
   logic        carry;
   logic [63:0] q;
   logic [7:0]  shift_n;
   logic        shift_right, sticky, zero, busy, done;

   int errors = 0;
   int checks = 0;

   normalize_counter #(.SIZE(64), .COARSE(8)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_d          (d),
      .i_carry      (carry),
      .o_q          (q),
      .o_shift_n    (shift_n),
      .o_shift_right(shift_right),
      .o_sticky     (sticky),
      .o_zero       (zero),
      .o_busy       (busy),
      .o_done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [63:0] d;
      logic        carry;
      logic [63:0] q;
      logic [7:0]  sn;
      logic        right;
      logic        sticky;
      logic        zero;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      @(negedge clk);
      d = v.d; carry = v.carry; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({v.name, " latency"}, 64'(lat), 64'(v.lat));
      check({v.name, " q"}, q, v.q);
      check({v.name, " shift_n"}, 64'(shift_n), 64'(v.sn));
      check({v.name, " flags"}, {61'd0, shift_right, sticky, zero},
            {61'd0, v.right, v.sticky, v.zero});
      @(posedge clk); #1;
      check({v.name, " done/busy after"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      logic [63:0] q_hold;

      vecs[0] = '{"msb_set",  64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 8'd0,  1'b0, 1'b0, 1'b0, 2};
      vecs[1] = '{"one",      64'h0000_0000_0000_0001, 1'b0, 64'h8000_0000_0000_0000, 8'd63, 1'b0, 1'b0, 1'b0, 16};
      vecs[2] = '{"zero",     64'h0,                   1'b0, 64'h0,                   8'd0,  1'b0, 1'b0, 1'b1, 1};
      vecs[3] = '{"carry3",   64'h3,                   1'b1, 64'h8000_0000_0000_0001, 8'd1,  1'b1, 1'b1, 1'b0, 1};
      vecs[4] = '{"l8",       64'h00FF_0000_0000_0000, 1'b0, 64'hFF00_0000_0000_0000, 8'd8,  1'b0, 1'b0, 1'b0, 3};
      vecs[5] = '{"l1",       64'h7FFF_0000_0000_0001, 1'b0, 64'hFFFE_0000_0000_0002, 8'd1,  1'b0, 1'b0, 1'b0, 3};
      vecs[6] = '{"l15",      64'h0001_0000_0000_0001, 1'b0, 64'h8000_0000_0000_8000, 8'd15, 1'b0, 1'b0, 1'b0, 10};
      vecs[7] = '{"carry_ev", 64'hF000_0000_0000_0010, 1'b1, 64'hF800_0000_0000_0008, 8'd1,  1'b1, 1'b0, 1'b0, 1};
      vecs[8] = '{"carry_z",  64'h0,                   1'b1, 64'h8000_0000_0000_0000, 8'd1,  1'b1, 1'b0, 1'b0, 1};
      vecs[9] = '{"l7",       64'h0100_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 8'd7,  1'b0, 1'b0, 1'b0, 9};

      rst_n = 1'b0; start = 1'b0; d = '0; carry = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset q", q, 64'd0);
      check("reset status", {56'd0, shift_n}, 64'd0);
      check("reset flags", {59'd0, shift_right, sticky, zero, busy, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Start ignored while busy: second pulse lands on the third edge
      @(negedge clk);
      d = 64'h0000_0100_0000_0000; carry = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin
         if (lat == 2) begin
            @(negedge clk);
            start = 1'b1; d = 64'h0000_0000_0000_00FF; carry = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
         lat++;
      end
      check("busy_start latency", 64'(lat), 64'd11);
      check("busy_start q", q, 64'h8000_0000_0000_0000);
      check("busy_start shift_n", 64'(shift_n), 64'd23);
      q_hold = q;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         if (done || busy) pulses++;
      end
      check("busy_start no requeue", 64'(pulses), 64'd0);
      check("busy_start q hold", q, q_hold);

      // Reset in the middle of LEFT
      @(negedge clk);
      d = 64'h1; carry = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid busy before rst", 64'(busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid rst q", q, 64'd0);
      check("mid rst outs", {53'd0, shift_n, shift_right, sticky, zero, busy, done}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
